// File: rtl/game_timer_bcd.sv
// game_timer_bcd: single-clock game timer with an internal one-second tick
// divider, a BCD elapsed-seconds counter, time-limit loss detection, and a
// best (lowest) completion time kept across games.
// Optional build macro COUNTDOWN_EN: time_bcd shows the remaining seconds
// (LIMIT - elapsed) from a separate BCD down-counter instead of elapsed time.
module game_timer_bcd #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 100000000,
    parameter int LIMIT    = 999
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  win_flag,
    input  logic                  best_clr,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic                  best_valid,
    output logic                  new_best,
    output logic                  running,
    output logic                  lose_flag,
    output logic                  win_latched
);

    localparam int W     = 4 * DIGITS;
    localparam int DIV_W = $clog2(TICK_DIV);

    // Elaboration-time conversion of a decimal integer to packed BCD.
    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           t;
        r = {W{1'b0}};
        t = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // BCD increment with per-digit carry 9 -> 0.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c && (v[4*i +: 4] == 4'd9)) begin
                r[4*i +: 4] = 4'd0;
            end else if (c) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef COUNTDOWN_EN
    // BCD decrement with per-digit borrow 0 -> 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b && (v[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'd9;
            end else if (b) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                b = 1'b0;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction
`endif

    localparam logic [W-1:0]     LIMIT_BCD = to_bcd(LIMIT);
    localparam logic [W-1:0]     ALL_NINES = {DIGITS{4'h9}};
    localparam logic [W-1:0]     ZERO_BCD  = {W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [W-1:0]     elapsed_q, elapsed_d;
    logic [W-1:0]     best_q, best_d;
    logic             best_valid_q, best_valid_d;
    logic             new_best_q, new_best_d;
    logic             running_q, lose_q, won_q;

    logic             tick_s;
    logic             run_tick_s;
    logic             win_entry_s;
    logic             limit_hit_s;
    logic [W-1:0]     elapsed_inc_s;

    // A tick only counts when no start or win takes precedence this cycle.
    assign tick_s        = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign run_tick_s    = tick_s && !start && !win_flag;
    assign win_entry_s   = !start && (state_q == ST_RUN) && win_flag;
    assign elapsed_inc_s = bcd_inc(elapsed_q);

`ifdef COUNTDOWN_EN
    logic [W-1:0] remain_q, remain_d;
    logic [W-1:0] remain_dec_s;

    assign remain_dec_s = bcd_dec(remain_q);
    assign limit_hit_s  = (remain_dec_s == ZERO_BCD);
    assign time_bcd     = remain_q;

    // Remaining-time counter: reload on start, step down on each accepted tick.
    always_comb begin
        remain_d = remain_q;
        if (start) begin
            remain_d = LIMIT_BCD;
        end else if (run_tick_s) begin
            remain_d = remain_dec_s;
        end else begin
            remain_d = remain_q;
        end
    end

    // Remaining-time register, preset to the full limit.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            remain_q <= LIMIT_BCD;
        end else begin
            remain_q <= remain_d;
        end
    end
`else
    assign limit_hit_s = (elapsed_inc_s == LIMIT_BCD);
    assign time_bcd    = elapsed_q;
`endif

    assign best_bcd    = best_q;
    assign best_valid  = best_valid_q;
    assign new_best    = new_best_q;
    assign running     = running_q;
    assign lose_flag   = lose_q;
    assign win_latched = won_q;

    // Game FSM next state, tick divider and elapsed-seconds counter.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        elapsed_d = elapsed_q;
        if (start) begin
            state_d   = ST_RUN;
            div_d     = {DIV_W{1'b0}};
            elapsed_d = ZERO_BCD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (win_flag) begin
                        state_d = ST_WON;
                    end else if (tick_s) begin
                        div_d     = {DIV_W{1'b0}};
                        elapsed_d = elapsed_inc_s;
                        if (limit_hit_s) begin
                            state_d = ST_LOST;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_IDLE, ST_WON, ST_LOST: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Best-time bookkeeping; packed BCD compares correctly as plain binary.
    always_comb begin
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_best_d   = 1'b0;
        if (win_entry_s && (!best_valid_q || (elapsed_q < best_q))) begin
            best_d       = elapsed_q;
            best_valid_d = 1'b1;
            new_best_d   = 1'b1;
        end else if (best_clr) begin
            best_d       = ALL_NINES;
            best_valid_d = 1'b0;
        end else begin
            new_best_d   = 1'b0;
        end
    end

    // State, counters, best time and registered status flags.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            div_q        <= {DIV_W{1'b0}};
            elapsed_q    <= ZERO_BCD;
            best_q       <= ALL_NINES;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
            running_q    <= 1'b0;
            lose_q       <= 1'b0;
            won_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            elapsed_q    <= elapsed_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_best_q   <= new_best_d;
            running_q    <= (state_d == ST_RUN);
            lose_q       <= (state_d == ST_LOST);
            won_q        <= (state_d == ST_WON);
        end
    end

endmodule

// File: tb/tb_game_timer_bcd.sv
// Testbench for game_timer_bcd: directed scenarios plus randomized pulses,
// checked against an integer-seconds reference model.
module tb_game_timer_bcd;

    localparam int LIM  = 12;
    localparam int TD   = 4;
    localparam int LIM2 = 999;
    localparam int TD2  = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n, start, win_flag, best_clr;
    logic [11:0] time_bcd, best_bcd;
    logic        best_valid, new_best, running, lose_flag, win_latched;

    logic        clr2_n, start2, win2, bclr2;
    logic [11:0] time2, best2;
    logic        valid2, nb2, run2, lose2, won2;

    game_timer_bcd #(.DIGITS(3), .TICK_DIV(TD), .LIMIT(LIM)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .win_flag(win_flag),
        .best_clr(best_clr), .time_bcd(time_bcd), .best_bcd(best_bcd),
        .best_valid(best_valid), .new_best(new_best), .running(running),
        .lose_flag(lose_flag), .win_latched(win_latched)
    );

    game_timer_bcd #(.DIGITS(3), .TICK_DIV(TD2), .LIMIT(LIM2)) dut2 (
        .clk(clk), .clr_n(clr2_n), .start(start2), .win_flag(win2),
        .best_clr(bclr2), .time_bcd(time2), .best_bcd(best2),
        .best_valid(valid2), .new_best(nb2), .running(run2),
        .lose_flag(lose2), .win_latched(won2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 idle, 1 running, 2 won, 3 lost.
    int m_phase, m_secs, m_cyc, m_best;
    bit m_valid, m_nb;

    function automatic logic [11:0] bcd12(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int shown(input int secs, input int lim);
`ifdef COUNTDOWN_EN
        return lim - secs;
`else
        return secs + 0 * lim;
`endif
    endfunction

    function automatic logic [28:0] exp_vec();
        return {bcd12(shown(m_secs, LIM)), bcd12(m_best), m_valid, m_nb,
                (m_phase == 1), (m_phase == 3), (m_phase == 2)};
    endfunction

    function automatic logic [28:0] obs_vec();
        return {time_bcd, best_bcd, best_valid, new_best, running, lose_flag, win_latched};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_secs = 0; m_cyc = 0; m_best = 999; m_valid = 1'b0; m_nb = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit w, input bit b);
        bit tick, upd;
        tick = (m_phase == 1) && (m_cyc == TD - 1);
        upd  = 1'b0;
        if (s) begin
            m_phase = 1; m_secs = 0; m_cyc = 0;
        end else if (m_phase == 1 && w) begin
            m_phase = 2;
            upd = !m_valid || (m_secs < m_best);
        end else if (m_phase == 1 && tick) begin
            m_secs = m_secs + 1;
            m_cyc  = 0;
            if (m_secs == LIM) m_phase = 3;
        end else if (m_phase == 1) begin
            m_cyc = m_cyc + 1;
        end
        if (upd) begin
            m_best = m_secs; m_valid = 1'b1;
        end else if (b) begin
            m_best = 999; m_valid = 1'b0;
        end
        m_nb = upd;
    endtask

    task automatic step(input bit s, input bit w, input bit b);
        start = s; win_flag = w; best_clr = b;
        @(posedge clk);
        model_step(s, w, b);
        @(negedge clk);
        start = 1'b0; win_flag = 1'b0; best_clr = 1'b0;
    endtask

    task automatic step2(input bit s);
        start2 = s;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; clr2_n = 1'b0;
        start = 1'b0; win_flag = 1'b0; best_clr = 1'b0;
        start2 = 1'b0; win2 = 1'b0; bclr2 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        n_total++;
        if (best_bcd !== 12'h999) $display("FAIL reset_best: got %h expected 999", best_bcd);
        else n_pass++;
        clr_n = 1'b1; clr2_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL idle_win_ignored: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_count_up();
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if (running !== 1'b1) $display("FAIL start_running: got %b expected 1", running);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL count_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (time_bcd !== bcd12(shown(10, LIM))) $display("FAIL time_after_40: got %h expected %h", time_bcd, bcd12(shown(10, LIM)));
        else n_pass++;
    endtask

    task automatic test_limit();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL limit_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (lose_flag !== 1'b1 || time_bcd !== bcd12(shown(LIM, LIM)))
            $display("FAIL limit_reached: got lose=%b time=%h expected lose=1 time=%h", lose_flag, time_bcd, bcd12(shown(LIM, LIM)));
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 3), 1'b0);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL lost_hold%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_best_sequence();
        int secs_tab[3]  = '{7, 5, 9};
        int best_tab[3]  = '{7, 5, 5};
        int pulse_tab[3] = '{1, 1, 0};
        for (int g = 0; g < 3; g++) begin
            int pulses = 0;
            step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 4 * secs_tab[g]; i++) begin
                step(1'b0, 1'b0, 1'b0);
                n_total++;
                if (obs_vec() !== exp_vec()) $display("FAIL best_run%0d_c%0d: got %h expected %h", g, i, obs_vec(), exp_vec());
                else n_pass++;
            end
            step(1'b0, 1'b1, 1'b0);
            pulses += int'(new_best);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL best_win%0d: got %h expected %h", g, obs_vec(), exp_vec());
            else n_pass++;
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(new_best);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL best_after%0d: got %h expected %h", g, obs_vec(), exp_vec());
            else n_pass++;
            n_total++;
            if (best_bcd !== bcd12(best_tab[g]) || pulses != pulse_tab[g])
                $display("FAIL best_value%0d: got best=%h pulses=%0d expected best=%h pulses=%0d",
                         g, best_bcd, pulses, bcd12(best_tab[g]), pulse_tab[g]);
            else n_pass++;
        end
    endtask

    task automatic test_win_vs_limit();
        step(1'b1, 1'b0, 1'b0);
        repeat (47) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (win_latched !== 1'b1 || lose_flag !== 1'b0 || time_bcd !== bcd12(shown(11, LIM)))
            $display("FAIL win_beats_limit: got won=%b lose=%b time=%h expected won=1 lose=0 time=%h",
                     win_latched, lose_flag, time_bcd, bcd12(shown(11, LIM)));
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL win_limit_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_total++;
        if (running !== 1'b1 || win_latched !== 1'b0 || time_bcd !== bcd12(shown(0, LIM)))
            $display("FAIL start_beats_win: got run=%b won=%b time=%h expected run=1 won=0 time=%h",
                     running, win_latched, time_bcd, bcd12(shown(0, LIM)));
        else n_pass++;
    endtask

    task automatic test_best_clr();
        repeat (8) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_total++;
        if (best_valid !== 1'b0 || best_bcd !== 12'h999)
            $display("FAIL best_clr: got valid=%b best=%h expected valid=0 best=999", best_valid, best_bcd);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_total++;
        if (best_bcd !== bcd12(3) || best_valid !== 1'b1 || new_best !== 1'b1)
            $display("FAIL clr_vs_win: got best=%h valid=%b nb=%b expected best=003 valid=1 nb=1", best_bcd, best_valid, new_best);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL clr_vs_win_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bit s, w, b;
            s = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 44) == 0);
            b = ($urandom_range(0, 199) == 0);
            step(s, w, b);
            n_total++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_c%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_carry();
        step2(1'b1);
        repeat (198) step2(1'b0);
        n_total++;
        if (time2 !== bcd12(shown(99, LIM2))) $display("FAIL carry_099: got %h expected %h", time2, bcd12(shown(99, LIM2)));
        else n_pass++;
        repeat (2) step2(1'b0);
        n_total++;
        if (time2 !== bcd12(shown(100, LIM2))) $display("FAIL carry_100: got %h expected %h", time2, bcd12(shown(100, LIM2)));
        else n_pass++;
        repeat (1797) step2(1'b0);
        n_total++;
        if (run2 !== 1'b1 || lose2 !== 1'b0 || time2 !== bcd12(shown(998, LIM2)))
            $display("FAIL before_999: got run=%b lose=%b time=%h expected run=1 lose=0 time=%h",
                     run2, lose2, time2, bcd12(shown(998, LIM2)));
        else n_pass++;
        step2(1'b0);
        n_total++;
        if (lose2 !== 1'b1 || run2 !== 1'b0 || time2 !== bcd12(shown(999, LIM2)))
            $display("FAIL lost_999: got lose=%b run=%b time=%h expected lose=1 run=0 time=%h",
                     lose2, run2, time2, bcd12(shown(999, LIM2)));
        else n_pass++;
        step2(1'b1);
        repeat (21) step2(1'b0);
        #2 clr2_n = 1'b0;
        #1;
        n_total++;
        if ({time2, best2, valid2, nb2, run2, lose2, won2} !== {bcd12(shown(0, LIM2)), 12'h999, 5'b00000})
            $display("FAIL async_clear: got %h expected %h", {time2, best2, valid2, nb2, run2, lose2, won2},
                     {bcd12(shown(0, LIM2)), 12'h999, 5'b00000});
        else n_pass++;
        @(negedge clk);
        clr2_n = 1'b1;
        repeat (3) step2(1'b0);
        n_total++;
        if (run2 !== 1'b0 || time2 !== bcd12(shown(0, LIM2)))
            $display("FAIL idle_after_clear: got run=%b time=%h expected run=0 time=%h", run2, time2, bcd12(shown(0, LIM2)));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_limit();
        test_best_sequence();
        test_win_vs_limit();
        test_best_clr();
        test_random();
        test_carry();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
Parametrised single-clock game timer for the Sudoku datapath. It replaces the separate 1 Hz clock input with an internal tick divider. It counts elapsed seconds as N BCD digits and raises a lose flag at a configurable limit. On a win it freezes and keeps a best (lowest) completion time. It feeds the seven-segment display mux and the game-control FSM.

Parameters:
DIGITS, 3, number of BCD digits in time_bcd and best_bcd (1..6)
TICK_DIV, 100000000, clk cycles per one-second tick (>=2)
LIMIT, 999, time limit in seconds, decimal integer, must be < 10**DIGITS and >0

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear elapsed time and begin counting
win_flag  in  1  level/pulse from board checker: puzzle solved
best_clr  in  1  one-cycle pulse: invalidate best time
time_bcd  out  4*DIGITS  displayed time, digit 0 = LSB nibble
best_bcd  out  4*DIGITS  best completion time
best_valid  out  1  best_bcd holds a real result
new_best  out  1  one-cycle pulse when best_bcd is updated
running  out  1  high in RUN state
lose_flag  out  1  high in LOST state
win_latched  out  1  high in WON state

Behaviour:
- Reset (clr_n=0, async): state IDLE. Divider=0. Elapsed=0. time_bcd=0. best_bcd=all digits 9. best_valid=0. All flags 0.
- FSM states: IDLE, RUN, WON, LOST. Registered outputs: running=(RUN), win_latched=(WON), lose_flag=(LOST).
- start in any state: elapsed<=0, divider<=0, state<=RUN on the next edge. start has priority over win_flag and tick in the same cycle.
- Divider: counts 0..TICK_DIV-1 only in RUN and holds otherwise. tick is asserted combinationally when divider==TICK_DIV-1 in RUN. First tick comes TICK_DIV cycles after entering RUN.
- On tick: elapsed increments as BCD with per-digit carry 9->0. No overflow is possible because LIMIT < 10**DIGITS.
- RUN->LOST: on the tick where the incremented elapsed equals LIMIT. time_bcd shows LIMIT and lose_flag rises on the same edge.
- RUN->WON: when win_flag=1 and no start is pending. Elapsed freezes at its current value, and any tick that cycle is ignored. win_flag beats a simultaneous limit tick, so the game is won, not lost.
- On the WON transition: if best_valid=0 or elapsed<best_bcd (BCD magnitude compare), then best_bcd<=elapsed, best_valid<=1, and new_best pulses for exactly 1 cycle, aligned with win_latched rising.
- WON and LOST hold until start or reset. win_flag in IDLE, WON or LOST is ignored.
- best_clr: best_bcd<=all 9s and best_valid<=0 next edge. If it coincides with a WON transition, the update wins.
- time_bcd is a direct register output with no extra latency beyond the state/elapsed registers.
- best_bcd survives start. Only clr_n and best_clr reset it.

Optional Feature:
COUNTDOWN_EN:
- Defined: time_bcd shows remaining = LIMIT - elapsed, kept in a separate BCD down-counter. It loads LIMIT on start and reset, and decrements on tick with borrow 0->9. LOST is entered when it reaches 0.
- best_bcd still stores elapsed seconds, compared as lowest.
- Not defined: time_bcd = elapsed (count up). The down-counter is not synthesised.

Test Plan (DIGITS=3, TICK_DIV=4, LIMIT=12 unless noted):
1. Reset, then start: running=1 next edge. After 40 cycles time_bcd=0x010. Ticks are exactly 4 cycles apart.
2. Run to limit: at 48 cycles after start, time_bcd=0x012 and lose_flag=1. Further cycles produce no change. win_flag afterwards is ignored.
3. Win at 0x007, then restart and win at 0x005: best_bcd=0x007 then 0x005, with new_best pulsed once each time. A third win at 0x009 leaves best=0x005 with no pulse.
4. win_flag asserted in the same cycle as the limit tick (elapsed 0x011): WON, time_bcd=0x011, lose_flag=0. start+win_flag in the same cycle restarts at 0.
5. LIMIT=999, TICK_DIV=2: carry chain 0x099->0x100 and 0x999 -> LOST. clr_n pulsed mid-RUN gives IDLE with time 0, best all 9s, best_valid=0.
6. COUNTDOWN_EN defined, LIMIT=12: start loads time_bcd=0x012. After 3 ticks it reads 0x009. At 0x000, lose_flag=1. A win at remaining 0x004 stores best_bcd=0x008.
